// File: rtl/boundary_move_checker.sv
// Player-movement gate: probes every footprint pixel of the target position against the
// registered walkable map and commits the move only if all of it is walkable and on-screen.
module boundary_move_checker #(
  parameter int SPRITE_W = 3,
  parameter int SPRITE_H = 3,
  parameter int X_MAX    = 95,
  parameter int Y_MAX    = 63,
  parameter int START_X  = 46,
  parameter int START_Y  = 5,
  parameter int MAP_LAT  = 1
) (
  input  logic       clk50,
  input  logic       rst_n,
  input  logic       move_req,
  input  logic [1:0] move_dir,
  input  logic       map_in,
  output logic [6:0] probe_x,
  output logic [6:0] probe_y,
  output logic [6:0] player_x,
  output logic [6:0] player_y,
  output logic       busy,
  output logic       move_done,
  output logic       move_ok
);

  typedef enum logic [1:0] {IDLE, SCAN, DRAIN, DONE} state_t;

  localparam int DW = (MAP_LAT > 2) ? $clog2(MAP_LAT) : 1;
  localparam logic signed [8:0] X_LIM = 9'(X_MAX - SPRITE_W + 1);
  localparam logic signed [8:0] Y_LIM = 9'(Y_MAX - SPRITE_H + 1);
  localparam logic [2:0] IX_LAST = 3'(SPRITE_W - 1);
  localparam logic [2:0] IY_LAST = 3'(SPRITE_H - 1);

  state_t r_state;
  state_t w_state_nxt;

  logic [6:0]       r_tx, r_ty;
  logic [2:0]       r_ix, r_iy;
  logic [6:0]       r_probe_x, r_probe_y;
  logic [6:0]       r_player_x, r_player_y;
  logic [MAP_LAT:0] r_tag;
  logic             r_ok_acc;
  logic [DW-1:0]    r_drain;
  logic             r_move_done, r_move_ok;

  logic signed [8:0] w_tx, w_ty;
  logic              w_oob;
  logic              w_last;
  logic              w_issue;
  logic              w_ok_next;

  always_comb begin
    w_tx = $signed({2'b00, r_player_x});
    w_ty = $signed({2'b00, r_player_y});
    case (move_dir)
      2'd0:    w_ty = w_ty - 9'sd1;
      2'd1:    w_ty = w_ty + 9'sd1;
      2'd2:    w_tx = w_tx - 9'sd1;
      default: w_tx = w_tx + 9'sd1;
    endcase
  end

  assign w_oob  = w_tx[8] | w_ty[8] | (w_tx > X_LIM) | (w_ty > Y_LIM);
  assign w_last = (r_ix == IX_LAST) && (r_iy == IY_LAST);

  assign w_issue = ((r_state == IDLE) && move_req && !w_oob) ||
                   ((r_state == SCAN) && !w_last);

  // A tag leaving the top of the pipe means map_in now answers the probe it was issued with.
  assign w_ok_next = r_ok_acc & (~r_tag[MAP_LAT] | map_in);

  always_ff @(posedge clk50 or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  // Out-of-bounds requests take one empty drain cycle so the reject resolves at E0+1.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (move_req) w_state_nxt = w_oob ? DRAIN : SCAN;
      SCAN:    if (w_last) w_state_nxt = DRAIN;
      DRAIN:   if (r_drain == '0) w_state_nxt = DONE;
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk50 or negedge rst_n) begin
    if (!rst_n) begin
      r_tx        <= '0;
      r_ty        <= '0;
      r_ix        <= '0;
      r_iy        <= '0;
      r_probe_x   <= '0;
      r_probe_y   <= '0;
      r_player_x  <= 7'(START_X);
      r_player_y  <= 7'(START_Y);
      r_tag       <= '0;
      r_ok_acc    <= 1'b0;
      r_drain     <= '0;
      r_move_done <= 1'b0;
      r_move_ok   <= 1'b0;
    end else begin
      r_tag       <= {r_tag[MAP_LAT-1:0], w_issue};
      r_ok_acc    <= w_ok_next;
      r_move_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (move_req) begin
            r_ok_acc <= ~w_oob;
            r_drain  <= '0;
            r_ix     <= '0;
            r_iy     <= '0;
            if (!w_oob) begin
              r_tx      <= w_tx[6:0];
              r_ty      <= w_ty[6:0];
              r_probe_x <= w_tx[6:0];
              r_probe_y <= w_ty[6:0];
            end
          end
        end
        SCAN: begin
          if (w_last) begin
            r_drain <= DW'(MAP_LAT - 1);
          end else if (r_ix == IX_LAST) begin
            r_ix      <= '0;
            r_iy      <= r_iy + 3'd1;
            r_probe_x <= r_tx;
            r_probe_y <= r_probe_y + 7'd1;
          end else begin
            r_ix      <= r_ix + 3'd1;
            r_probe_x <= r_probe_x + 7'd1;
          end
        end
        DRAIN: begin
          if (r_drain != '0) begin
            r_drain <= r_drain - DW'(1);
          end else begin
            r_move_done <= 1'b1;
            r_move_ok   <= w_ok_next;
            if (w_ok_next) begin
              r_player_x <= r_tx;
              r_player_y <= r_ty;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign probe_x   = r_probe_x;
  assign probe_y   = r_probe_y;
  assign player_x  = r_player_x;
  assign player_y  = r_player_y;
  assign busy      = (r_state != IDLE);
  assign move_done = r_move_done;
  assign move_ok   = r_move_ok;

endmodule

// File: tb/tb_boundary_move_checker.sv
// Bench for boundary_move_checker: a walkable-map neighbour with one cycle of latency,
// a footprint-level reference model checked every cycle, and directed moves with literal results.
`timescale 1ns/1ps
module tb_boundary_move_checker;

  localparam int W   = 3;
  localparam int H   = 3;
  localparam int LAT = 1;

  logic       clk50 = 1'b0;
  logic       rst_n = 1'b0;
  logic       move_req = 1'b0;
  logic [1:0] move_dir = 2'd0;
  logic       map_in;
  logic [6:0] probe_x, probe_y, player_x, player_y;
  logic       busy, move_done, move_ok;

  logic       e_req = 1'b0;
  logic [1:0] e_dir = 2'd0;
  logic [6:0] e_prx, e_pry, e_plx, e_ply;
  logic       e_busy, e_done, e_ok;

  int n_checks = 0;
  int n_err    = 0;
  int rec_x[W*H];
  int rec_y[W*H];

  always #10 clk50 = ~clk50;

  boundary_move_checker #(.SPRITE_W(W), .SPRITE_H(H), .X_MAX(95), .Y_MAX(63),
                          .START_X(46), .START_Y(5), .MAP_LAT(LAT)) dut (
    .clk50(clk50), .rst_n(rst_n), .move_req(move_req), .move_dir(move_dir), .map_in(map_in),
    .probe_x(probe_x), .probe_y(probe_y), .player_x(player_x), .player_y(player_y),
    .busy(busy), .move_done(move_done), .move_ok(move_ok)
  );

  boundary_move_checker #(.SPRITE_W(W), .SPRITE_H(H), .X_MAX(95), .Y_MAX(63),
                          .START_X(0), .START_Y(40), .MAP_LAT(LAT)) dut_edge (
    .clk50(clk50), .rst_n(rst_n), .move_req(e_req), .move_dir(e_dir), .map_in(1'b1),
    .probe_x(e_prx), .probe_y(e_pry), .player_x(e_plx), .player_y(e_ply),
    .busy(e_busy), .move_done(e_done), .move_ok(e_ok)
  );

  // Walkable map: 4-pixel border is blocked, plus one obstacle pixel at (48,8).
  function automatic bit walk(input int x, input int y);
    if (x < 4 || x > 91 || y < 4 || y > 59) return 1'b0;
    if (x == 48 && y == 8) return 1'b0;
    return 1'b1;
  endfunction

  always @(posedge clk50 or negedge rst_n) begin
    if (!rst_n) map_in <= 1'b0;
    else        map_in <= walk(int'(probe_x), int'(probe_y));
  end

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual %0d required %0d at t=%0t", name, act, exp, $time);
    end
  endtask

  logic       s_req;
  logic [1:0] s_dir;
  always @(posedge clk50) begin
    s_req <= move_req;
    s_dir <= move_dir;
  end

  // Reference model: a move resolves a fixed number of edges after acceptance, with the
  // result decided by bounds and a footprint sweep of the map.
  bit m_idle, m_oob, m_res;
  int m_e0, m_done, m_tx, m_ty, m_px, m_py, m_ok, m_prx, m_pry, cyc;

  always @(negedge clk50) begin : model
    int dx, dy, i;
    if (!rst_n) begin
      m_idle = 1'b1; m_oob = 1'b1; m_res = 1'b0;
      m_px = 46; m_py = 5; m_ok = 0; m_prx = 0; m_pry = 0;
      m_e0 = 0; m_done = -10; cyc = 0;
      chk("rst_busy", int'(busy), 0);
      chk("rst_done", int'(move_done), 0);
      chk("rst_player_x", int'(player_x), 46);
      chk("rst_player_y", int'(player_y), 5);
    end else begin
      cyc++;
      if (m_idle) begin
        if (s_req === 1'b1) begin
          dx = 0; dy = 0;
          case (s_dir)
            2'd0: dy = -1;
            2'd1: dy = 1;
            2'd2: dx = -1;
            default: dx = 1;
          endcase
          m_tx  = m_px + dx;
          m_ty  = m_py + dy;
          m_oob = (m_tx < 0) || (m_ty < 0) || (m_tx + W - 1 > 95) || (m_ty + H - 1 > 63);
          m_res = !m_oob;
          if (!m_oob)
            for (int y = 0; y < H; y++)
              for (int x = 0; x < W; x++)
                if (!walk(m_tx + x, m_ty + y)) m_res = 1'b0;
          m_e0   = cyc;
          m_done = cyc + (m_oob ? 1 : W * H + LAT);
          m_idle = 1'b0;
        end
      end else if (cyc == m_done + 1) begin
        m_idle = 1'b1;
      end
      if (!m_idle && cyc == m_done) begin
        m_ok = int'(m_res);
        if (m_res) begin m_px = m_tx; m_py = m_ty; end
      end
      if (!m_idle && !m_oob && (cyc - m_e0) < W * H) begin
        i = cyc - m_e0;
        m_prx = m_tx + i % W;
        m_pry = m_ty + i / W;
      end
      chk("busy", int'(busy), int'(!m_idle));
      chk("move_done", int'(move_done), int'(!m_idle && cyc == m_done));
      chk("move_ok", int'(move_ok), m_ok);
      chk("player_x", int'(player_x), m_px);
      chk("player_y", int'(player_y), m_py);
      chk("probe_x", int'(probe_x), m_prx);
      chk("probe_y", int'(probe_y), m_pry);
    end
  end

  // Issues one request; lat is the edge offset of move_done from the accepting edge (-1 if none).
  task automatic do_move(input logic [1:0] dir, input int pulse_at, input int rst_at,
                         output int lat);
    lat = -1;
    @(posedge clk50); #1;
    move_req = 1'b1; move_dir = dir;
    @(posedge clk50); #1;
    move_req = 1'b0;
    for (int k = 0; k < 40; k++) begin
      if (k < W * H) begin rec_x[k] = int'(probe_x); rec_y[k] = int'(probe_y); end
      if (move_done === 1'b1) begin lat = k; break; end
      if (k == rst_at) begin
        rst_n = 1'b0;
        #1;
        chk("async_rst_probe_x", int'(probe_x), 0);
        chk("async_rst_probe_y", int'(probe_y), 0);
        chk("async_rst_player_y", int'(player_y), 5);
        chk("async_rst_busy", int'(busy), 0);
        chk("async_rst_ok", int'(move_ok), 0);
        return;
      end
      if (k + 1 == pulse_at) begin move_req = 1'b1; move_dir = 2'd3; end
      else move_req = 1'b0;
      @(posedge clk50); #1;
    end
    move_req = 1'b0;
  endtask

  task automatic pulse_reset();
    @(posedge clk50); #1; rst_n = 1'b0;
    repeat (2) @(posedge clk50);
    #1; rst_n = 1'b1;
  endtask

  initial begin
    int lat;
    repeat (3) @(posedge clk50);
    #1;
    chk("init_player_x", int'(player_x), 46);
    chk("init_player_y", int'(player_y), 5);
    chk("init_probe_x", int'(probe_x), 0);
    chk("init_ok", int'(move_ok), 0);
    rst_n = 1'b1;

    do_move(2'd0, -1, -1, lat);
    chk("t1_latency", lat, 10);
    chk("t1_ok", int'(move_ok), 1);
    chk("t1_player_y", int'(player_y), 4);
    chk("t6_probe0_x", rec_x[0], 46); chk("t6_probe0_y", rec_y[0], 4);
    chk("t6_probe1_x", rec_x[1], 47);
    chk("t6_probe3_x", rec_x[3], 46); chk("t6_probe3_y", rec_y[3], 5);
    chk("t6_probe8_x", rec_x[8], 48); chk("t6_probe8_y", rec_y[8], 6);

    do_move(2'd0, -1, -1, lat);
    chk("t2_latency", lat, 10);
    chk("t2_ok", int'(move_ok), 0);
    chk("t2_player_y", int'(player_y), 4);

    do_move(2'd1, -1, -1, lat);
    chk("down_ok", int'(move_ok), 1);
    chk("down_player_y", int'(player_y), 5);

    do_move(2'd1, -1, -1, lat);
    chk("obstacle_last_px_latency", lat, 10);
    chk("obstacle_last_px_ok", int'(move_ok), 0);
    chk("obstacle_player_y", int'(player_y), 5);

    do_move(2'd3, -1, -1, lat);
    chk("right_ok", int'(move_ok), 1);
    chk("right_player_x", int'(player_x), 47);

    pulse_reset();
    do_move(2'd0, 4, -1, lat);
    chk("t4_latency", lat, 10);
    chk("t4_ok", int'(move_ok), 1);
    chk("t4_player_x", int'(player_x), 46);
    chk("t4_player_y", int'(player_y), 4);
    repeat (15) @(posedge clk50);

    do_move(2'd1, -1, 5, lat);
    chk("t5_no_done", lat, -1);
    repeat (2) @(posedge clk50);
    #1; rst_n = 1'b1;
    repeat (15) @(posedge clk50);
    #1;
    chk("t5_player_y", int'(player_y), 5);

    @(posedge clk50); #1;
    e_req = 1'b1; e_dir = 2'd2;
    @(posedge clk50); #1;
    e_req = 1'b0;
    chk("t3_e0_done", int'(e_done), 0);
    chk("t3_e0_busy", int'(e_busy), 1);
    @(posedge clk50); #1;
    chk("t3_e1_done", int'(e_done), 1);
    chk("t3_e1_ok", int'(e_ok), 0);
    chk("t3_player_x", int'(e_plx), 0);
    chk("t3_player_y", int'(e_ply), 40);
    chk("t3_probe_x", int'(e_prx), 0);
    chk("t3_probe_y", int'(e_pry), 0);
    @(posedge clk50); #1;
    chk("t3_e2_done", int'(e_done), 0);
    chk("t3_e2_busy", int'(e_busy), 0);

    @(posedge clk50); #1;
    e_req = 1'b1; e_dir = 2'd0;
    @(posedge clk50); #1;
    e_req = 1'b0;
    lat = -1;
    for (int k = 0; k < 30; k++) begin
      if (e_done === 1'b1) begin lat = k; break; end
      @(posedge clk50); #1;
    end
    chk("edge_up_latency", lat, 10);
    chk("edge_up_ok", int'(e_ok), 1);
    chk("edge_up_player_y", int'(e_ply), 39);

    repeat (3) @(posedge clk50);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
